// File: rtl/axi_burst_writer.sv
// AXI4 INCR-burst write master fed by an AXI-Stream; splits on MAX_BURST_LEN and 4 KB pages.
// Optional bresp error flag enabled by defining AXI_BURST_WRITER_BRESP_CHECK_EN.
module axi_burst_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AWID_VALUE    = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  err
);

  localparam int SIZE = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_rem, w_rem_nxt;
  logic [8:0]            r_cnt, w_cnt_nxt;
  logic [8:0]            r_beats, w_beats_nxt;
  logic                  r_awvalid, r_bready, r_done, w_done_nxt;
  logic                  w_err_clr, w_err_set;
  logic [8:0]            w_burst;
  logic                  w_in_data, w_xfer, w_last;
  logic                  w_unused;

  // Beats in the next burst: limited by words left, MAX_BURST_LEN and room to the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [11:0] off,
                                             input logic [LEN_WIDTH-1:0] rem);
    logic [12:0] room;
    logic [12:0] cap;
    room = (13'd4096 - {1'b0, off}) >> SIZE;
    cap  = (room < 13'(MAX_BURST_LEN)) ? room : 13'(MAX_BURST_LEN);
    if (32'(rem) < 32'(cap)) return 9'(rem);
    return 9'(cap);
  endfunction

  assign w_burst   = burst_beats(r_addr[11:0], r_rem);
  assign w_in_data = (r_state == S_DATA);
  assign w_last    = (r_cnt == 9'd1);
  assign w_xfer    = w_in_data && s_axis_tvalid && m_axi_wready;
  assign w_unused  = ^{m_axi_bid, m_axi_bresp};

  always_comb begin
    w_next      = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_beats_nxt = r_beats;
    w_done_nxt  = 1'b0;
    w_err_clr   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_err_clr = 1'b1;
          if (cmd_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_addr_nxt = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            w_rem_nxt  = cmd_len;
            w_next     = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (r_awvalid && m_axi_awready) begin
          w_cnt_nxt   = w_burst;
          w_beats_nxt = w_burst;
          w_next      = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_cnt_nxt = r_cnt - 9'd1;
          if (r_rem != '0) w_rem_nxt = r_rem - LEN_WIDTH'(1);
          if (w_last) begin
            w_addr_nxt = r_addr + (ADDR_WIDTH'(r_beats) << SIZE);
            w_next     = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (m_axi_bvalid && r_bready) begin
          w_err_set = (m_axi_bresp != 2'b00);
          if (r_rem != '0) begin
            w_next = S_ADDR;
          end else begin
            w_next     = S_IDLE;
            w_done_nxt = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // awvalid/bready are registered from the next state so they rise on state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_beats   <= '0;
      r_awvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addr_nxt;
      r_rem     <= w_rem_nxt;
      r_cnt     <= w_cnt_nxt;
      r_beats   <= w_beats_nxt;
      r_awvalid <= (w_next == S_ADDR);
      r_bready  <= (w_next == S_RESP);
      r_done    <= w_done_nxt;
    end
  end

`ifdef AXI_BURST_WRITER_BRESP_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst || w_err_clr) r_err <= 1'b0;
    else if (w_err_set)   r_err <= 1'b1;
  end
  assign err = r_err;
`else
  logic w_err_unused;
  assign w_err_unused = w_err_clr ^ w_err_set;
  assign err = 1'b0;
`endif

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign s_axis_tready = w_in_data && m_axi_wready;
  assign m_axi_awid    = ID_WIDTH'(AWID_VALUE);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'(w_burst - 9'd1);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_in_data && w_last;
  assign m_axi_wvalid  = w_in_data && s_axis_tvalid;
  assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Bench for axi_burst_writer: random-stall AXI slave, stream source and a burst-splitting reference model.
module tb_axi_burst_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid, cmd_ready, busy, done, err;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [7:0]  m_axi_awid, m_axi_bid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst, m_axi_bresp;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;

  always #5 clk = ~clk;

  axi_burst_writer dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .busy(busy), .done(done),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit stall = 1'b0;
  int err_burst = -1;

  logic [31:0] mem [0:16383];
  logic [15:0] aw_addr_q[$];
  int          aw_len_q[$];
  logic [31:0] wd_q[$];
  bit          wl_q[$];
  int          b_num = 0, done_cnt = 0, b_cyc = 0, done_cyc = 0;
  bit          b_pending = 1'b0, b_clear = 1'b0, aw_wait = 1'b0;
  logic [15:0] held_addr, cur;
  logic [7:0]  held_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI slave: drive readies/B at negedge, observe handshakes just before the posedge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      b_pending = 1'b0;
      b_clear   = 1'b0;
      aw_wait   = 1'b0;
    end else begin
      m_axi_awready = !stall || ($urandom_range(0, 2) != 0);
      m_axi_wready  = !stall || ($urandom_range(0, 2) != 0);
      if (b_clear) begin
        m_axi_bvalid = 1'b0;
        b_clear = 1'b0;
      end
      if (b_pending && !m_axi_bvalid) begin
        m_axi_bvalid = !stall || ($urandom_range(0, 1) == 1);
        m_axi_bresp  = (b_num == err_burst) ? 2'b10 : 2'b00;
      end
    end
    #4;
    if (!rst) begin
      if (aw_wait) begin
        chk("aw_hold_valid", m_axi_awvalid, 1'b1);
        chk("aw_hold_addr", m_axi_awaddr, held_addr);
        chk("aw_hold_len", m_axi_awlen, held_len);
      end
      aw_wait   = m_axi_awvalid && !m_axi_awready;
      held_addr = m_axi_awaddr;
      held_len  = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_q.push_back(m_axi_awaddr);
        aw_len_q.push_back(int'(m_axi_awlen));
        cur = m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        mem[cur[15:2]] = m_axi_wdata;
        wd_q.push_back(m_axi_wdata);
        wl_q.push_back(m_axi_wlast);
        cur = cur + 16'd4;
        if (m_axi_wlast) b_pending = 1'b1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pending = 1'b0;
        b_clear   = 1'b1;
        b_num++;
        b_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_cmd(input logic [15:0] base, input int n, input bit gaps, input bit slv_stall);
    logic [31:0] exp_data[$];
    logic [15:0] exp_addr[$];
    int          exp_len[$];
    logic [15:0] a;
    int          rem, room, b, idx, t, acc_cyc, k;
    bit          timed_out;
    // Reference: split the command into bursts by plain arithmetic.
    a = base & 16'hFFFC;
    rem = n;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_addr.push_back(a);
      exp_len.push_back(b - 1);
      a = a + 16'(b * 4);
      rem -= b;
    end
    for (int i = 0; i < n; i++) exp_data.push_back($urandom);
    aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete(); wl_q.delete();
    b_num = 0; done_cnt = 0; b_cyc = -10; done_cyc = -10;
    stall = slv_stall;

    @(negedge clk);
    cmd_addr = base; cmd_len = 16'(n); cmd_valid = 1'b1;
    #4;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    acc_cyc = cyc;
    idx = 0; t = 0;
    while (idx < n && t < 4000) begin
      @(negedge clk);
      t++;
      if (t <= 2 && n >= 2) begin
        cmd_valid = 1'b1; cmd_addr = 16'h3000; cmd_len = 16'd7;
      end else begin
        cmd_valid = 1'b0;
      end
      s_axis_tvalid = !gaps || ($urandom_range(0, 2) != 0);
      s_axis_tdata  = exp_data[idx];
      #4;
      if (t <= 2 && n >= 2) chk("cmd_ready_busy", cmd_ready, 1'b0);
      if (s_axis_tvalid && s_axis_tready) idx++;
    end
    timed_out = (idx < n);
    @(negedge clk);
    s_axis_tvalid = 1'b0; cmd_valid = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(negedge clk);
      #4;
      t++;
    end
    if (t >= 4000) timed_out = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("timeout", timed_out, 1'b0);
    chk("done_count", done_cnt, 1);
    if (n == 0) chk("done_latency_len0", done_cyc, acc_cyc + 1);
    else        chk("done_after_b", done_cyc, b_cyc + 1);
    chk("burst_count", aw_addr_q.size(), exp_addr.size());
    chk("b_count", b_num, exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < aw_addr_q.size(); i++) begin
      chk("awaddr", aw_addr_q[i], exp_addr[i]);
      chk("awlen", aw_len_q[i], exp_len[i]);
    end
    chk("word_count", wd_q.size(), n);
    for (int i = 0; i < n && i < wd_q.size(); i++) chk("wdata_order", wd_q[i], exp_data[i]);
    for (int i = 0; i < n; i++) begin
      a = (base & 16'hFFFC) + 16'(4 * i);
      chk("mem", mem[a[15:2]], exp_data[i]);
    end
    k = 0;
    for (int j = 0; j < exp_len.size(); j++) begin
      for (int bt = 0; bt <= exp_len[j]; bt++) begin
        if (k < wl_q.size()) chk("wlast", wl_q[k], (bt == exp_len[j]));
        k++;
      end
    end
`ifdef AXI_BURST_WRITER_BRESP_CHECK_EN
    chk("err", err, (err_burst >= 0 && err_burst < exp_addr.size()));
`else
    chk("err", err, 1'b0);
`endif
  endtask

  initial begin
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axi_bid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #4;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("awsize", m_axi_awsize, 3'd2);
    chk("awburst", m_axi_awburst, 2'b01);
    chk("awcache", m_axi_awcache, 4'b0011);
    chk("aw_const", {m_axi_awid, m_axi_awlock, m_axi_awprot, m_axi_wstrb}, {8'd0, 1'b0, 3'd0, 4'hF});

    run_cmd(16'h0100, 4, 1'b0, 1'b0);
    run_cmd(16'h0000, 40, 1'b0, 1'b0);
    run_cmd(16'h0FF8, 6, 1'b0, 1'b0);
    run_cmd(16'h0200, 0, 1'b0, 1'b0);
    run_cmd(16'h0F40, 33, 1'b1, 1'b1);
    run_cmd(16'hFFF0, 8, 1'b1, 1'b1);

    err_burst = 1;
    run_cmd(16'h2000, 40, 1'b1, 1'b1);
    err_burst = -1;
    run_cmd(16'h0400, 0, 1'b0, 1'b0);

    // Reset in the middle of a data burst.
    stall = 1'b0;
    @(negedge clk);
    cmd_addr = 16'h0800; cmd_len = 16'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD_BEEF;
    t = 0;
    #4;
    while (!s_axis_tready && t < 50) begin
      @(negedge clk);
      #4;
      t++;
    end
    chk("reach_data", s_axis_tready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #4;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_awvalid", m_axi_awvalid, 1'b0);
    chk("mid_rst_wvalid", m_axi_wvalid, 1'b0);
    chk("mid_rst_bready", m_axi_bready, 1'b0);
    chk("mid_rst_tready", s_axis_tready, 1'b0);
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 3; r++)
      run_cmd(16'($urandom) & 16'hFFFC, int'($urandom_range(1, 70)), 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_burst_writer.md
Name: axi_burst_writer

Overview:
- AXI4 write master sitting directly upstream of the on-chip AXI4 RAM in the Rectify datapath.
- Accepts a command of base address plus word count, then consumes an AXI-Stream of data words.
- Writes the words to memory as INCR bursts: one outstanding burst at a time, split on MAX_BURST_LEN and 4 KB boundaries.
- Signals completion with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 32, AXI/stream data width in bits; multiple of 8, power of two.
- ADDR_WIDTH, 16, AXI byte-address width.
- STRB_WIDTH, DATA_WIDTH/8, bytes per word.
- ID_WIDTH, 8, AXI ID width.
- AWID_VALUE, 0, constant driven on m_axi_awid.
- MAX_BURST_LEN, 16, max beats per burst, 1..256.
- LEN_WIDTH, 16, width of the command word count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (forced 0).
- cmd_len  in  LEN_WIDTH  number of words to write.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- s_axis_tdata  in  DATA_WIDTH  input word.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axi_awid  out  ID_WIDTH  = AWID_VALUE.
- m_axi_awaddr  out  ADDR_WIDTH  burst start address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  = log2(STRB_WIDTH).
- m_axi_awburst  out  2  = 2'b01 (INCR).
- m_axi_awlock  out  1  = 0.
- m_axi_awcache  out  4  = 4'b0011.
- m_axi_awprot  out  3  = 0.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  DATA_WIDTH  = s_axis_tdata.
- m_axi_wstrb  out  STRB_WIDTH  all ones.
- m_axi_wlast  out  1  last beat of burst.
- m_axi_wvalid  out  1  write valid.
- m_axi_wready  in  1  write ready.
- m_axi_bid  in  ID_WIDTH  ignored.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.
- err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset values: state IDLE, cmd_ready=1 (IDLE), busy=0, done=0, m_axi_awvalid=0, m_axi_wvalid=0, m_axi_bready=0, s_axis_tready=0, err=0; internal address and counters cleared.

State machine (IDLE, ADDR, DATA, RESP):
- IDLE:
  - cmd_valid&cmd_ready with cmd_len=0 → done pulses next cycle, stay IDLE, no AXI traffic.
  - cmd_len>0 → latch aligned address and remaining=cmd_len, go ADDR.
- ADDR:
  - Registered awvalid asserts on ADDR entry and holds, with awaddr/awlen stable, until awready.
  - Burst beats = min(remaining, MAX_BURST_LEN, (4096 - awaddr[11:0]) / STRB_WIDTH), computed before awvalid rises.
  - On awvalid&awready: load beat counter, go DATA.
- DATA:
  - m_axi_wvalid = s_axis_tvalid; s_axis_tready = m_axi_wready. Combinational pass-through, zero-latency, no buffering.
  - wlast = (beat counter == 1).
  - Each transfer (wvalid&wready) decrements beat counter and remaining.
  - Transfer with wlast → go RESP; address += beats*STRB_WIDTH.
- RESP:
  - bready=1 (registered, asserted on RESP entry).
  - On bvalid&bready: if remaining>0 go ADDR, else go IDLE and pulse done the same cycle IDLE is entered.
- Outside DATA: wvalid=0 and tready=0. Stream words are never consumed outside a burst.

Arithmetic and boundaries:
- Address adds wrap modulo 2^ADDR_WIDTH.
- remaining never underflows.
- Bursts never cross a 4 KB boundary.
- MAX_BURST_LEN=256 → awlen=255.
- cmd_valid during busy is ignored; cmd_ready=0.
- rst mid-burst returns to IDLE immediately and drops all valids; the in-flight AXI transaction is abandoned, and the system must reset the slave as well.

Optional Feature:
AXI_BURST_WRITER_BRESP_CHECK_EN
- Defined: any accepted response with bresp≠2'b00 sets err. err stays set until rst or until the next command is accepted. Transfer still completes normally.
- Undefined: bresp ignored, err tied 0.

Test Plan:
- cmd_addr=0x0100, cmd_len=4, stream 4 words, always-ready slave → one burst awaddr=0x0100, awlen=3, wlast on 4th beat, done 1 cycle after B handshake, memory words 0x40..0x43 hold data.
- cmd_addr=0x0000, cmd_len=40, MAX_BURST_LEN=16 → bursts awlen=15,15,7 at awaddr 0x000, 0x040, 0x080; exactly one done.
- cmd_addr=0x0FF8, cmd_len=6, DATA_WIDTH=32 → awlen=1 at 0x0FF8, then awlen=3 at 0x1000 (4 KB split).
- cmd_len=0 → done pulse next cycle, awvalid never asserted.
- Random tvalid gaps, random awready/wready/bready stalls, cmd_len=33 → data order preserved, no word dropped or duplicated, awaddr/awlen stable while awvalid&!awready.
- With AXI_BURST_WRITER_BRESP_CHECK_EN: slave returns bresp=2'b10 on 2nd of 3 bursts → err=1 after that B, done still pulses; err clears on next cmd accept. Additionally, rst asserted mid-DATA → next cycle busy=0, awvalid=wvalid=bready=tready=0.
